fdiv_srt_iter_ctrl: RTL and testbench

- Sequencing FSM for the radix-4 x2 SRT floating-point divide datapath, which produces 4 quotient bits per iteration cycle.
- Accepts one divide operation per start handshake and drives the iteration control strobes: iter_start, iter_vld, iter_end and iter_counter.
- Computes the count of quotient bits produced and the one-hot discard count for the final quotient, per format and per the dividend<divisor flag.
- Returns completion to the FPU through a valid/ready finish handshake and supports abort.

---
 rtl/fdiv_srt_iter_ctrl.sv | 92 +++++++++
 tb/tb_fdiv_srt_iter_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fdiv_srt_iter_ctrl.sv
// fdiv_srt_iter_ctrl: iteration sequencer for the radix-4 x2 SRT divider (4 quotient bits per cycle),
// with start/finish handshakes, early finish, abort and final-quotient discard count.
module fdiv_srt_iter_ctrl #(
    parameter int F64_ITER_NUM = 14,
    parameter int F32_ITER_NUM = 7,
    parameter int F16_ITER_NUM = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid_i,
    output logic       start_ready_o,
    input  logic [1:0] fp_format_i,
    input  logic       dividend_lt_divisor_i,
    input  logic       early_finish_i,
    input  logic       kill_i,
    output logic       iter_start_o,
    output logic       iter_vld_o,
    output logic       iter_end_o,
    output logic [5:0] iter_counter_o,
    output logic [5:0] quot_bits_calculated_o,
    output logic [3:0] quot_discard_num_one_hot_o,
    output logic       finish_valid_o,
    input  logic       finish_ready_i,
    output logic       early_finish_o
);
    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, WAIT_ACK} state_t;
    // Discard for lt=1 (mantissa+2 bits needed); lt=0 needs one more bit, so one fewer discard.
    localparam logic [1:0] F64_DISC = 2'(4 * F64_ITER_NUM - 55);
    localparam logic [1:0] F32_DISC = 2'(4 * F32_ITER_NUM - 26);
    localparam logic [1:0] F16_DISC = 2'(4 * F16_ITER_NUM - 13);
    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] fmt_q, fmt_d;
    logic       lt_q, lt_d;
    logic       ef_q, ef_d;
    logic [5:0] last_cnt;
    logic [1:0] disc;
    assign last_cnt = (fmt_q == 2'd0 ? 6'(F16_ITER_NUM) : fmt_q == 2'd1 ? 6'(F32_ITER_NUM) : 6'(F64_ITER_NUM)) - 6'd1;
    assign disc = (fmt_q == 2'd0 ? F16_DISC : fmt_q == 2'd1 ? F32_DISC : F64_DISC) - {1'b0, ~lt_q};
    assign start_ready_o              = state_q == IDLE;
    assign iter_start_o               = state_q == PRE;
    assign iter_vld_o                 = state_q == ITER;
    assign iter_end_o                 = iter_vld_o && cnt_q == last_cnt;
    assign iter_counter_o             = cnt_q;
    assign quot_bits_calculated_o     = {cnt_q[3:0] + 4'd1, 2'b00};
    assign quot_discard_num_one_hot_o = 4'b0001 << disc;
    assign finish_valid_o             = state_q == WAIT_ACK;
    assign early_finish_o             = ef_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fmt_d   = fmt_q;
        lt_d    = lt_q;
        ef_d    = ef_q;
        if (kill_i && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                IDLE: if (start_valid_i && !kill_i) begin
                    fmt_d   = fp_format_i == 2'd3 ? 2'd2 : fp_format_i;
                    lt_d    = dividend_lt_divisor_i;
                    ef_d    = early_finish_i;
                    state_d = early_finish_i ? POST : PRE;
                end
                PRE:  state_d = ITER;
                ITER: begin
                    state_d = iter_end_o ? POST : ITER;
                    cnt_d   = iter_end_o ? 6'd0 : cnt_q + 6'd1;
                end
                POST: state_d = WAIT_ACK;
                WAIT_ACK: state_d = finish_ready_i ? IDLE : WAIT_ACK;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            fmt_q   <= 2'd2;
            lt_q    <= 1'b0;
            ef_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fmt_q   <= fmt_d;
            lt_q    <= lt_d;
            ef_q    <= ef_d;
        end
    end
endmodule

// File: tb/tb_fdiv_srt_iter_ctrl.sv
// tb_fdiv_srt_iter_ctrl: directed and random stimulus against a cycle-timeline model of the divide sequencer.
module tb_fdiv_srt_iter_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start_valid = 1'b0, lt = 1'b0, ef = 1'b0, kill = 1'b0, fready = 1'b1;
    logic [1:0] fmt = 2'd0;
    logic       start_ready_o, iter_start_o, iter_vld_o, iter_end_o, finish_valid_o, early_finish_o;
    logic [5:0] iter_counter_o, quot_bits_o;
    logic [3:0] disc_oh_o;
    int vectors = 0, miscompares = 0, cycle = 0, t0 = 0;

    fdiv_srt_iter_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid_i(start_valid), .start_ready_o(start_ready_o),
        .fp_format_i(fmt), .dividend_lt_divisor_i(lt), .early_finish_i(ef), .kill_i(kill),
        .iter_start_o(iter_start_o), .iter_vld_o(iter_vld_o), .iter_end_o(iter_end_o),
        .iter_counter_o(iter_counter_o), .quot_bits_calculated_o(quot_bits_o),
        .quot_discard_num_one_hot_o(disc_oh_o),
        .finish_valid_o(finish_valid_o), .finish_ready_i(fready), .early_finish_o(early_finish_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Model: an op is described only by how many cycles have elapsed since it was accepted.
    int m_busy = 0, m_t = 0, m_n = 14, m_mant = 53, m_ef = 0, m_lt = 0;
    int e_ready, e_start, e_vld, e_cnt, e_end, e_fv, e_quot, e_disc;
    always_comb begin
        e_ready = m_busy != 0 ? 0 : 1;
        e_start = (m_busy != 0 && m_ef == 0 && m_t == 1) ? 1 : 0;
        e_vld   = (m_busy != 0 && m_ef == 0 && m_t >= 2 && m_t <= m_n + 1) ? 1 : 0;
        e_cnt   = e_vld != 0 ? m_t - 2 : 0;
        e_end   = (e_vld != 0 && m_t == m_n + 1) ? 1 : 0;
        e_fv    = (m_busy != 0 && m_t >= (m_ef != 0 ? 2 : m_n + 3)) ? 1 : 0;
        e_quot  = 4 * (e_cnt + 1);
        e_disc  = 4 * m_n - (m_mant + 2 + (m_lt != 0 ? 0 : 1));
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_t    <= 0;
        end else if (m_busy == 0) begin
            if (start_valid && !kill) begin
                m_busy <= 1;
                m_t    <= 1;
                m_n    <= fmt == 2'd0 ? 4 : fmt == 2'd1 ? 7 : 14;
                m_mant <= fmt == 2'd0 ? 11 : fmt == 2'd1 ? 24 : 53;
                m_ef   <= ef ? 1 : 0;
                m_lt   <= lt ? 1 : 0;
            end
        end else if (kill || (e_fv != 0 && fready)) begin
            m_busy <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        chk("start_ready", int'(start_ready_o), e_ready);
        chk("iter_start", int'(iter_start_o), e_start);
        chk("iter_vld", int'(iter_vld_o), e_vld);
        chk("iter_end", int'(iter_end_o), e_end);
        chk("iter_counter", int'(iter_counter_o), e_cnt);
        chk("finish_valid", int'(finish_valid_o), e_fv);
        if (e_end != 0) begin
            chk("quot_bits", int'(quot_bits_o), e_quot);
            chk("discard_one_hot", int'(disc_oh_o), 1 << e_disc);
        end
        if (e_fv != 0) chk("early_finish", int'(early_finish_o), m_ef);
    end

    task automatic cyc(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask
    task automatic go(input int f, input bit l, input bit e);
        start_valid = 1'b1;
        fmt = 2'(f);
        lt = l;
        ef = e;
        t0 = cycle;
        cyc();
        start_valid = 1'b0;
    endtask
    task automatic at_rel(input int k);
        while (cycle < t0 + k) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        cyc(3);
        chk("lit_reset_ready", int'(start_ready_o), 1);
        chk("lit_reset_fv", int'(finish_valid_o), 0);
        rst_n = 1'b1;
        cyc(2);
        go(2, 1'b1, 1'b0);
        at_rel(1);  chk("lit_f64_iter_start", int'(iter_start_o), 1);
        at_rel(2);  chk("lit_f64_first_vld", int'(iter_vld_o), 1);
        at_rel(15); chk("lit_f64_end", int'(iter_end_o), 1);
        chk("lit_f64_cnt", int'(iter_counter_o), 13);
        chk("lit_f64_quot", int'(quot_bits_o), 56);
        chk("lit_f64_disc", int'(disc_oh_o), 2);
        at_rel(16); chk("lit_f64_post_fv", int'(finish_valid_o), 0);
        at_rel(17); chk("lit_f64_fv", int'(finish_valid_o), 1);
        cyc(2);
        go(1, 1'b0, 1'b0);
        at_rel(8);  chk("lit_f32_end", int'(iter_end_o), 1);
        chk("lit_f32_quot", int'(quot_bits_o), 28);
        chk("lit_f32_disc", int'(disc_oh_o), 2);
        at_rel(10); chk("lit_f32_fv", int'(finish_valid_o), 1);
        cyc(2);
        go(0, 1'b1, 1'b0);
        at_rel(5);  chk("lit_f16_end", int'(iter_end_o), 1);
        chk("lit_f16_quot", int'(quot_bits_o), 16);
        chk("lit_f16_disc", int'(disc_oh_o), 8);
        at_rel(7);  chk("lit_f16_fv", int'(finish_valid_o), 1);
        cyc(2);
        go(2, 1'b0, 1'b1);
        at_rel(1);  chk("lit_ef_no_start", int'(iter_start_o), 0);
        at_rel(2);  chk("lit_ef_fv", int'(finish_valid_o), 1);
        chk("lit_ef_flag", int'(early_finish_o), 1);
        cyc(2);
        ef = 1'b0;
        fready = 1'b0;
        go(1, 1'b0, 1'b0);
        at_rel(10);
        for (int i = 0; i < 5; i++) begin
            cyc();
            start_valid = (i % 2 == 0);
            #3;
            chk("lit_bp_fv", int'(finish_valid_o), 1);
            chk("lit_bp_ready", int'(start_ready_o), 0);
        end
        cyc();
        start_valid = 1'b0;
        fready = 1'b1;
        cyc();
        #3;
        chk("lit_bp_idle", int'(start_ready_o), 1);
        cyc(2);
        go(2, 1'b1, 1'b0);
        at_rel(8);  chk("lit_kill_cnt", int'(iter_counter_o), 6);
        kill = 1'b1;
        cyc();
        kill = 1'b0;
        #3;
        chk("lit_kill_ready", int'(start_ready_o), 1);
        chk("lit_kill_vld", int'(iter_vld_o), 0);
        chk("lit_kill_cnt0", int'(iter_counter_o), 0);
        cyc(3);
        go(1, 1'b0, 1'b0);
        at_rel(10); chk("lit_after_kill_fv", int'(finish_valid_o), 1);
        cyc(2);
        go(0, 1'b0, 1'b0);
        at_rel(5);  chk("lit_rst_cnt", int'(iter_counter_o), 3);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_ready", int'(start_ready_o), 1);
        chk("lit_rst_vld", int'(iter_vld_o), 0);
        chk("lit_rst_cnt0", int'(iter_counter_o), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc();
        go(0, 1'b1, 1'b0);
        at_rel(5);  chk("lit_rst_full_end", int'(iter_end_o), 1);
        at_rel(7);  chk("lit_rst_full_fv", int'(finish_valid_o), 1);
        cyc(2);
        for (int i = 0; i < 4000; i++) begin
            start_valid = ($urandom_range(3) == 0);
            fmt = 2'($urandom_range(3));
            lt = 1'($urandom_range(1));
            ef = ($urandom_range(7) == 0);
            kill = ($urandom_range(39) == 0);
            fready = 1'($urandom_range(1));
            cyc();
        end
        start_valid = 1'b0;
        kill = 1'b0;
        fready = 1'b1;
        cyc(30);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
